// File: rtl/dtw_accel_s00_axis_pkg.sv
// Shared definitions for the DTW accelerator AXI4-Stream ports: the receive
// FSM encoding, the clogb2 sizing helper and the default widths and depths
// that the inbound slave and the outbound stream master have in common.
package dtw_accel_s00_axis_pkg;

  localparam int DTW_DATA_WIDTH = 32;
  localparam int DTW_FIFO_DEPTH = 16;
  localparam int DTW_PKT_WORDS  = 250;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RECV = 2'b01
  } axis_state_e;

  // Number of bits needed to index 'value' items (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dtw_accel_s00_axis_if.sv
// Bundle of the inbound AXI4-Stream beat signals and the FIFO pop port that
// the DTW core uses. 'slave' is the accelerator view, 'master' is the view of
// whoever drives the stream and pops words (DMA plus core, or a bench).
interface dtw_accel_s00_axis_if
  import dtw_accel_s00_axis_pkg::*;
#(
  parameter int DATA_W     = DTW_DATA_WIDTH,
  parameter int FIFO_DEPTH = DTW_FIFO_DEPTH
);

  logic                        S_AXIS_TVALID;
  logic [DATA_W-1:0]           S_AXIS_TDATA;
  logic [DATA_W/8-1:0]         S_AXIS_TSTRB;
  logic                        S_AXIS_TLAST;
  logic                        S_AXIS_TREADY;

  logic                        dtw_fifo_rden;
  logic [DATA_W-1:0]           dtw_fifo_dout;
  logic                        dtw_fifo_last;
  logic                        dtw_fifo_empty;
  logic                        dtw_fifo_full;
  logic [clogb2(FIFO_DEPTH):0] dtw_pkt_count;
  logic                        dtw_len_err;

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, dtw_fifo_rden,
    output S_AXIS_TREADY, dtw_fifo_dout, dtw_fifo_last, dtw_fifo_empty,
           dtw_fifo_full, dtw_pkt_count, dtw_len_err
  );

  modport master (
    output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, dtw_fifo_rden,
    input  S_AXIS_TREADY, dtw_fifo_dout, dtw_fifo_last, dtw_fifo_empty,
           dtw_fifo_full, dtw_pkt_count, dtw_len_err
  );

endinterface

// File: rtl/dtw_sync_fifo.sv
// Single-clock word FIFO with occupancy count and registered read data.
// Writes while full and pops while empty are ignored. head_tag exposes the
// MSB of the word at the head so a caller can see a per-word flag (such as
// TLAST) before popping it.
module dtw_sync_fifo
  import dtw_accel_s00_axis_pkg::*;
#(
  parameter int WIDTH = DTW_DATA_WIDTH + 1,
  parameter int DEPTH = DTW_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   head_tag,
  output logic [clogb2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = clogb2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_fire;
  logic             rd_fire;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_fire  = wr_en && !full;
  assign rd_fire  = rd_en && !empty;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign head_tag = mem_q[rd_ptr_q][WIDTH-1];

  // Next pointers, occupancy and read register; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state clears asynchronously so a reset drops any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/dtw_accel_s00_axis.sv
// Inbound AXI4-Stream slave of the DTW accelerator. Buffers samples together
// with their TLAST flag, counts complete packets held in the FIFO and, when
// HARU_S_AXIS_LEN_CHECK_EN is defined, flags packets whose length differs
// from C_PKT_WORDS with a sticky error.
module dtw_accel_s00_axis
  import dtw_accel_s00_axis_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = DTW_DATA_WIDTH,
  parameter int C_FIFO_DEPTH         = DTW_FIFO_DEPTH,
  parameter int C_PKT_WORDS          = DTW_PKT_WORDS
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  dtw_accel_s00_axis_if.slave   s_axis
);

  localparam int DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int CNT_W = clogb2(C_FIFO_DEPTH) + 1;

  axis_state_e      state_q, state_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] fifo_count;
  logic [DW:0]      fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_last;
  logic             tready;
  logic             beat_accept;
  logic             pop_fire;

  assign tready      = (state_q == ST_RECV) && (fifo_count != CNT_W'(C_FIFO_DEPTH));
  assign beat_accept = s_axis.S_AXIS_TVALID && tready;
  assign pop_fire    = s_axis.dtw_fifo_rden && !fifo_empty;

  assign s_axis.S_AXIS_TREADY  = tready;
  assign s_axis.dtw_fifo_dout  = fifo_rd_data[DW-1:0];
  assign s_axis.dtw_fifo_last  = fifo_rd_data[DW];
  assign s_axis.dtw_fifo_empty = fifo_empty;
  assign s_axis.dtw_fifo_full  = fifo_full;
  assign s_axis.dtw_pkt_count  = pkt_count_q;

  dtw_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk      (S_AXIS_ACLK),
    .rst      (S_AXIS_ARESET),
    .wr_en    (beat_accept),
    .wr_data  ({s_axis.S_AXIS_TLAST, s_axis.S_AXIS_TDATA}),
    .rd_en    (s_axis.dtw_fifo_rden),
    .rd_data  (fifo_rd_data),
    .head_tag (head_last),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Receive FSM: one idle cycle per packet, back to IDLE after the TLAST beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s_axis.S_AXIS_TVALID) state_d = ST_RECV;
      ST_RECV: if (beat_accept && s_axis.S_AXIS_TLAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Complete packets in the FIFO: up on a stored TLAST, down when one is popped.
  always_comb begin
    pkt_count_d = pkt_count_q;
    case ({beat_accept && s_axis.S_AXIS_TLAST, pop_fire && head_last})
      2'b10:   pkt_count_d = pkt_count_q + 1'b1;
      2'b01:   pkt_count_d = pkt_count_q - 1'b1;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // FSM and packet count registers.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q     <= ST_IDLE;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pkt_count_q <= pkt_count_d;
    end
  end

`ifdef HARU_S_AXIS_LEN_CHECK_EN
  localparam int BEAT_W = clogb2(C_PKT_WORDS) + 1;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beat_next;
  logic              len_err_q, len_err_d;

  // Per-packet beat counter; a short TLAST or an overlong packet sets the sticky error.
  always_comb begin
    beat_next  = beat_cnt_q + 1'b1;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    if (beat_accept) begin
      if (s_axis.S_AXIS_TLAST) begin
        beat_cnt_d = '0;
        if (beat_next != BEAT_W'(C_PKT_WORDS)) len_err_d = 1'b1;
      end else begin
        beat_cnt_d = beat_next;
        if (beat_next == BEAT_W'(C_PKT_WORDS)) len_err_d = 1'b1;
      end
    end
  end

  // Length check registers; the error only clears on reset.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign s_axis.dtw_len_err = len_err_q;
`else
  assign s_axis.dtw_len_err = 1'b0;
`endif

endmodule
